flash_scheduler: RTL and testbench

FLASH_SCHEDULER -- requirements
Module: flash_scheduler

---
 rtl/flash_scheduler.sv | 157 +++++++++++++++
 tb/tb_flash_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/flash_scheduler.sv
// Round-robin arbiter that hands one bound_flasher sequence at a time to N_REQ requesters.
// Optional watchdog abort enabled by defining FLASH_SCHED_TIMEOUT_EN.
module flash_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 200,
  parameter int TW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [15:0]      led_in,
  output logic             flick,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] GRANT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef logic [PW-1:0] ptr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLICK,
    S_WAIT_START,
    S_RUN,
    S_DONE
  } state_t;

  if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_nreq
    $error("flash_scheduler: N_REQ must be 2..8");
  end
  if ((TIMEOUT < 1) || (TIMEOUT >= (1 << TW))) begin : g_bad_timeout
    $error("flash_scheduler: TIMEOUT must be 1..2^TW-1");
  end

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  ptr_t             r_own, w_own_nxt;
  ptr_t             r_last_ptr, w_last_nxt;
  logic             r_flick, r_busy, r_done, r_timeout;
  logic             w_flick_nxt, w_busy_nxt, w_done_nxt, w_to_nxt;
  logic             w_found;
  ptr_t             w_win, w_cand;
  logic             w_expire;

`ifdef FLASH_SCHED_TIMEOUT_EN
  logic [TW-1:0] r_cnt;

  // Expire on the edge where the count would reach TIMEOUT.
  assign w_expire = ((r_state == S_WAIT_START) || (r_state == S_RUN)) &&
                    (r_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == S_FLICK) begin
      r_cnt <= '0;
    end else if (((r_state == S_WAIT_START) || (r_state == S_RUN)) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  // Upward search with wrap, starting just past the previous owner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = ptr_t'((32'(r_last_ptr) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_own_nxt   = r_own;
    w_last_nxt  = r_last_ptr;
    w_to_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_FLICK;
          w_grant_nxt = GRANT_LSB << w_win;
          w_own_nxt   = w_win;
        end
      end
      S_FLICK: w_state_nxt = S_WAIT_START;
      S_WAIT_START: begin
        if (w_expire) begin
          w_state_nxt = S_DONE;
          w_to_nxt    = 1'b1;
        end else if (led_in != '0) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_expire) begin
          w_state_nxt = S_DONE;
          w_to_nxt    = 1'b1;
        end else if (led_in == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_last_nxt  = r_own;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
    w_flick_nxt = (w_state_nxt == S_FLICK);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_own      <= '0;
      r_last_ptr <= ptr_t'(N_REQ - 1);
      r_flick    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_own      <= w_own_nxt;
      r_last_ptr <= w_last_nxt;
      r_flick    <= w_flick_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_timeout  <= w_to_nxt;
    end
  end

  assign flick   = r_flick;
  assign grant   = r_grant;
  assign busy    = r_busy;
  assign done    = r_done;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_flash_scheduler.sv
// Directed + randomized bench for flash_scheduler with a behavioural flasher stand-in on led_in.
module tb_flash_scheduler;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [15:0]  led_in;
  logic         flick;
  logic [N-1:0] grant;
  logic         busy, done, timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_last;

  int          cfg_d   = 0;
  int          cfg_len = 2;
  int          f_wait  = 0;
  int          f_on    = 0;
  logic        led_force = 1'b0;
  logic [15:0] f_pat   = 16'h00F0;

  always #5 clk = ~clk;

  flash_scheduler #(.N_REQ(N), .TIMEOUT(10), .TW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .led_in(led_in), .flick(flick),
    .grant(grant), .busy(busy), .done(done), .timeout(timeout)
  );

  // Flasher stand-in: after a flick, dark for cfg_d cycles, then lit for cfg_len cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_wait <= 0;
      f_on   <= 0;
    end else if (flick) begin
      f_wait <= cfg_d;
      f_on   <= cfg_len;
    end else if (f_wait > 0) begin
      f_wait <= f_wait - 1;
    end else if (f_on > 0) begin
      f_on <= f_on - 1;
    end
  end

  assign led_in = led_force ? 16'h0001 : (((f_wait == 0) && (f_on > 0)) ? f_pat : 16'h0000);

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full sequence starting from an IDLE cycle; rq_run is applied the cycle after led first lights (RUN).
  task automatic do_seq(input logic [N-1:0] rq, input logic [N-1:0] rq_run,
                        input bit drop, input int d, input int len);
    int w;
    int cyc;
    int lit_at;
    logic [31:0] oh;
    w      = rr_pick(rq, m_last);
    oh     = 32'(1) << w;
    cfg_d  = d;
    cfg_len = len;
    f_pat  = 16'($urandom_range(1, 16'hFFFF));
    req    = rq;
    step();
    chk("flick_pulse", 32'(flick), 1);
    chk("grant_on", 32'(grant), oh);
    chk("busy_on", 32'(busy), 1);
    chk("done_low", 32'(done), 0);
    if (drop) req = '0;
    cyc    = 0;
    lit_at = -10;
    step();
    while (!done && cyc < 40) begin
      chk("flick_once", 32'(flick), 0);
      chk("grant_hold", 32'(grant), oh);
      chk("busy_hold", 32'(busy), 1);
      if (lit_at < 0 && led_in != 16'h0000) lit_at = cyc;
      if (cyc == lit_at + 1 && !drop) req = rq_run;
      step();
      cyc++;
    end
    chk("done_pulse", 32'(done), 1);
    chk("grant_at_done", 32'(grant), oh);
    chk("busy_at_done", 32'(busy), 1);
    chk("timeout_low", 32'(timeout), 0);
    chk("flick_at_done", 32'(flick), 0);
    m_last = w;
    step();
    chk("done_clear", 32'(done), 0);
    chk("grant_clear", 32'(grant), 0);
    chk("busy_clear", 32'(busy), 0);
    chk("flick_idle", 32'(flick), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    logic [N-1:0] rq;
    rst = 1'b1;
    req = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_flick", 32'(flick), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    step();
    rst = 1'b1;
    m_last = N - 1;
    step();
    step();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_grant", 32'(grant), 0);

    // single 1-cycle request
    do_seq(4'b0001, 4'b0000, 1'b1, 1, 3);
    // contention held high
    for (int i = 0; i < 4; i++) do_seq(4'b1011, 4'b1011, 1'b0, i % 3, 1 + i);
    // owner drop
    do_seq(4'b0100, 4'b0000, 1'b1, 2, 2);
    // arrival during run: req[3] rises while req[0] held
    do_seq(4'b0001, 4'b1001, 1'b0, 1, 3);
    do_seq(4'b1001, 4'b0000, 1'b1, 0, 2);

    for (int i = 0; i < 14; i++) begin
      rq = N'($urandom_range(1, (1 << N) - 1));
      do_seq(rq, N'($urandom_range(0, (1 << N) - 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0) begin
        req = '0;
        for (int j = 0; j < 3; j++) begin
          step();
          chk("gap_busy", 32'(busy), 0);
          chk("gap_flick", 32'(flick), 0);
        end
      end
    end

`ifdef FLASH_SCHED_TIMEOUT_EN
    led_force = 1'b1;
    req = 4'b0001;
    w = rr_pick(req, m_last);
    step();
    chk("to_flick", 32'(flick), 1);
    req = '0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("to_early_done", 32'(done), 0);
      chk("to_early_timeout", 32'(timeout), 0);
    end
    step();
    chk("to_done", 32'(done), 1);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_grant", 32'(grant), 32'(1) << w);
    m_last = w;
    step();
    chk("to_idle_busy", 32'(busy), 0);
    chk("to_idle_done", 32'(done), 0);
    chk("to_idle_timeout", 32'(timeout), 0);
    led_force = 1'b0;
    step();
`else
    led_force = 1'b1;
    req = 4'b0001;
    step();
    chk("nto_flick", 32'(flick), 1);
    req = '0;
    for (int i = 0; i < 500; i++) begin
      step();
      chk("nto_busy", 32'(busy), 1);
      chk("nto_timeout", 32'(timeout), 0);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    led_force = 1'b0;
    m_last = N - 1;
    step();
`endif

    // reset mid-RUN
    cfg_d = 0;
    cfg_len = 4;
    req = 4'b0010;
    step();
    chk("mid_flick", 32'(flick), 1);
    req = '0;
    step();
    step();
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_flick", 32'(flick), 0);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_timeout", 32'(timeout), 0);
    step();
    rst = 1'b1;
    m_last = N - 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    do_seq(4'b1001, 4'b0000, 1'b1, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
